// File: rtl/frame_color_shape_classifier.sv
// -----------------------------------------------------------------------------
// frame_color_shape_classifier
//   Watches the RGB332 pixels read back from the frame buffer while the VGA
//   driver scans the stored window, accumulates per-frame red/blue pixel counts
//   and the coloured width of three sampling rows, and at the end of each
//   complete frame classifies the treasure colour and shape.
//
// Ports
//   CLK           in   pixel clock (VGA domain)
//   RESET_N       in   asynchronous active-low reset
//   PIXEL_IN      in   [7:0] RGB332 pixel, RD_LATENCY cycles behind VGA_PIXEL_X/Y
//   VGA_PIXEL_X   in   [9:0] current VGA scan column
//   VGA_PIXEL_Y   in   [9:0] current VGA scan row
//   RESULT        out  [2:0] bit2 = blue, bits[1:0] = shape (1 sq, 2 tri, 3 dia)
//   RESULT_VALID  out  one-cycle pulse whenever RESULT is updated
// -----------------------------------------------------------------------------
module frame_color_shape_classifier #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int RD_LATENCY    = 1,
  parameter int COLOR_THRESH  = 2000,
  parameter int BAND_Y0       = 36,
  parameter int BAND_Y1       = 72,
  parameter int BAND_Y2       = 108,
  parameter int WIDTH_TOL     = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PIXEL_IN,
  input  logic [9:0] VGA_PIXEL_X,
  input  logic [9:0] VGA_PIXEL_Y,
  output logic [2:0] RESULT,
  output logic       RESULT_VALID
);

  localparam logic [9:0]  LP_W    = 10'(SCREEN_WIDTH);
  localparam logic [9:0]  LP_H    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0]  LP_XL   = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  LP_YL   = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0]  LP_Y0   = 10'(BAND_Y0);
  localparam logic [9:0]  LP_Y1   = 10'(BAND_Y1);
  localparam logic [9:0]  LP_Y2   = 10'(BAND_Y2);
  localparam logic [14:0] LP_TH   = 15'(COLOR_THRESH);
  localparam logic [8:0]  LP_TOL  = 9'(WIDTH_TOL);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE} state_t;

  state_t      r_state;
  logic [9:0]  r_x_pipe [RD_LATENCY];
  logic [9:0]  r_y_pipe [RD_LATENCY];
  logic [14:0] r_red_cnt, r_blue_cnt;
  logic [7:0]  r_w0, r_w1, r_w2;

  logic [9:0]  w_dx, w_dy;
  logic        w_in_win, w_first, w_last, w_is_red, w_is_blue, w_is_col;
  logic        w_base_zero, w_acc;
  logic [14:0] w_red_nxt, w_blue_nxt;
  logic [7:0]  w_w0_nxt, w_w1_nxt, w_w2_nxt;
  logic [8:0]  w_sum0, w_sum2;
  logic        w_red_win, w_blue_win, w_diamond, w_triangle;
  logic [1:0]  w_shape;
  logic [2:0]  w_code;

  // Coordinate delay line so DX/DY line up with the frame-buffer read data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        r_x_pipe[i] <= '1;
        r_y_pipe[i] <= '1;
      end
    end else begin
      r_x_pipe[0] <= VGA_PIXEL_X;
      r_y_pipe[0] <= VGA_PIXEL_Y;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        r_x_pipe[i] <= r_x_pipe[i-1];
        r_y_pipe[i] <= r_y_pipe[i-1];
      end
    end
  end

  assign w_dx      = r_x_pipe[RD_LATENCY-1];
  assign w_dy      = r_y_pipe[RD_LATENCY-1];
  assign w_in_win  = (w_dx < LP_W) && (w_dy < LP_H);
  assign w_first   = (w_dx == '0) && (w_dy == '0);
  assign w_last    = (w_dx == LP_XL) && (w_dy == LP_YL);
  assign w_is_red  = (PIXEL_IN == 8'hE0);
  assign w_is_blue = (PIXEL_IN == 8'h03);
  assign w_is_col  = w_is_red || w_is_blue;

  // Counters restart from zero outside ACCUM and whenever (0,0) appears, so the
  // (0,0) pixel is always the first one of a fresh frame (IDLE, DECIDE or a
  // mid-frame restart all share this path).
  assign w_base_zero = (r_state != S_ACCUM) || w_first;
  assign w_acc       = w_in_win && ((r_state == S_ACCUM) || w_first);

  always_comb begin
    w_red_nxt  = w_base_zero ? '0 : r_red_cnt;
    w_blue_nxt = w_base_zero ? '0 : r_blue_cnt;
    w_w0_nxt   = w_base_zero ? '0 : r_w0;
    w_w1_nxt   = w_base_zero ? '0 : r_w1;
    w_w2_nxt   = w_base_zero ? '0 : r_w2;
    if (w_acc) begin
      if (w_is_red  && (w_red_nxt  != '1)) w_red_nxt  = w_red_nxt  + 1'b1;
      if (w_is_blue && (w_blue_nxt != '1)) w_blue_nxt = w_blue_nxt + 1'b1;
      if (w_is_col && (w_dy == LP_Y0) && (w_w0_nxt != '1)) w_w0_nxt = w_w0_nxt + 1'b1;
      if (w_is_col && (w_dy == LP_Y1) && (w_w1_nxt != '1)) w_w1_nxt = w_w1_nxt + 1'b1;
      if (w_is_col && (w_dy == LP_Y2) && (w_w2_nxt != '1)) w_w2_nxt = w_w2_nxt + 1'b1;
    end
  end

  // Classification of the finished frame, evaluated while in DECIDE.
  assign w_sum0     = {1'b0, r_w0} + LP_TOL;
  assign w_sum2     = {1'b0, r_w2} + LP_TOL;
  assign w_diamond  = ({1'b0, r_w1} > w_sum0) && ({1'b0, r_w1} > w_sum2);
  assign w_triangle = ({1'b0, r_w2} > w_sum0);
  assign w_shape    = w_diamond ? 2'd3 : (w_triangle ? 2'd2 : 2'd1);
  assign w_red_win  = (r_red_cnt  >= LP_TH) && (r_red_cnt  > r_blue_cnt);
  assign w_blue_win = (r_blue_cnt >= LP_TH) && (r_blue_cnt > r_red_cnt);
  assign w_code     = w_red_win  ? {1'b0, w_shape} :
                      w_blue_win ? {1'b1, w_shape} : 3'b000;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_red_cnt    <= '0;
      r_blue_cnt   <= '0;
      r_w0         <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
    end else begin
      r_red_cnt    <= w_red_nxt;
      r_blue_cnt   <= w_blue_nxt;
      r_w0         <= w_w0_nxt;
      r_w1         <= w_w1_nxt;
      r_w2         <= w_w2_nxt;
      RESULT_VALID <= 1'b0;
      case (r_state)
        S_IDLE:   if (w_first) r_state <= S_ACCUM;
        S_ACCUM:  if (w_last)  r_state <= S_DECIDE;
        S_DECIDE: begin
          RESULT       <= w_code;
          RESULT_VALID <= 1'b1;
          r_state      <= w_first ? S_ACCUM : S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_color_shape_classifier.sv
module tb_frame_color_shape_classifier;

  localparam int LAT = 1;
  localparam int W   = 176;
  localparam int H   = 144;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] PIXEL_IN;
  logic [9:0] VGA_PIXEL_X, VGA_PIXEL_Y;
  logic [2:0] RESULT;
  logic       RESULT_VALID;

  always #5 CLK = ~CLK;

  frame_color_shape_classifier #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .RD_LATENCY   (LAT),
    .COLOR_THRESH (2000),
    .BAND_Y0      (36),
    .BAND_Y1      (72),
    .BAND_Y2      (108),
    .WIDTH_TOL    (8)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PIXEL_IN    (PIXEL_IN),
    .VGA_PIXEL_X (VGA_PIXEL_X),
    .VGA_PIXEL_Y (VGA_PIXEL_Y),
    .RESULT      (RESULT),
    .RESULT_VALID(RESULT_VALID)
  );

  // One presented coordinate; exp >= 0 marks the last pixel of a frame whose
  // result must appear LAT+1 edges after the edge capturing this coordinate.
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] pix;
    int         exp;
  } step_t;

  step_t      q[$];
  int         n_pass   = 0;
  int         n_checks = 0;
  logic [2:0] hold     = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic step_t mk(input int x, input int y, input logic [7:0] p);
    step_t s;
    s.x = 10'(x); s.y = 10'(y); s.pix = p; s.exp = -1;
    return s;
  endfunction

  function automatic logic [7:0] bg_pix();
    logic [7:0] p;
    do p = 8'($urandom); while (p == 8'hE0 || p == 8'h03);
    return p;
  endfunction

  function automatic int ry_nonband(input int lo, input int hi);
    int y;
    do y = $urandom_range(hi, lo); while (y == 36 || y == 72 || y == 108);
    return y;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference classification from whole-frame totals.
  function automatic int classify(input int r, input int b, input int w0, input int w1, input int w2);
    int c, s;
    r = sat(r, 32767); b = sat(b, 32767);
    w0 = sat(w0, 255); w1 = sat(w1, 255); w2 = sat(w2, 255);
    if (r >= 2000 && r > b)      c = 0;
    else if (b >= 2000 && b > r) c = 4;
    else return 0;
    if (w1 > w0 + 8 && w1 > w2 + 8) s = 3;
    else if (w2 > w0 + 8)           s = 2;
    else                            s = 1;
    return c + s;
  endfunction

  // Full raster scan of one constant pixel value.
  task automatic raster(input logic [7:0] p);
    int r, b, w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) q.push_back(mk(x, y, p));
    r = (p == 8'hE0) ? W * H : 0;
    b = (p == 8'h03) ? W * H : 0;
    w = (p == 8'hE0 || p == 8'h03) ? W : 0;
    q[q.size()-1].exp = classify(r, b, w, w, w);
  endtask

  // Sparse frame: (0,0) pixel, shuffled body with the requested number of
  // coloured band/off-band pixels plus background and out-of-window noise,
  // then the final (W-1,H-1) background pixel.
  task automatic sparse_frame(input int rb0, input int rb1, input int rb2,
                              input int bb0, input int bb1, input int bb2,
                              input int ro, input int bo, input int nbg, input int noow,
                              input logic [7:0] p00);
    step_t b[$];
    step_t t;
    int    bands[3] = '{36, 72, 108};
    int    rc[3], bc[3];
    int    j, r, bl;
    rc = '{rb0, rb1, rb2};
    bc = '{bb0, bb1, bb2};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < rc[k]; i++) b.push_back(mk($urandom_range(W-1, 1), bands[k], 8'hE0));
      for (int i = 0; i < bc[k]; i++) b.push_back(mk($urandom_range(W-1, 1), bands[k], 8'h03));
    end
    for (int i = 0; i < ro; i++) b.push_back(mk($urandom_range(W-1, 0), ry_nonband(1, H-2), 8'hE0));
    for (int i = 0; i < bo; i++) b.push_back(mk($urandom_range(W-1, 0), ry_nonband(1, H-2), 8'h03));
    for (int i = 0; i < nbg; i++) b.push_back(mk($urandom_range(W-1, 0), $urandom_range(H-2, 1), bg_pix()));
    for (int i = 0; i < noow; i++) begin
      if (i % 2 == 0) b.push_back(mk($urandom_range(1023, W), $urandom_range(1023, 0), 8'($urandom)));
      else            b.push_back(mk($urandom_range(W-1, 0), $urandom_range(1023, H), 8'($urandom)));
    end
    for (int i = b.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = b[i]; b[i] = b[j]; b[j] = t;
    end
    q.push_back(mk(0, 0, p00));
    foreach (b[i]) q.push_back(b[i]);
    q.push_back(mk(W-1, H-1, bg_pix()));
    r  = rb0 + rb1 + rb2 + ro + ((p00 == 8'hE0) ? 1 : 0);
    bl = bb0 + bb1 + bb2 + bo + ((p00 == 8'h03) ? 1 : 0);
    q[q.size()-1].exp = classify(r, bl, rb0 + bb0, rb1 + bb1, rb2 + bb2);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(800, 600, 8'hE0));
  endtask

  // Plays the queue: coordinates and frame-buffer data (LAT cycles late) are
  // driven on the falling edge; outputs are checked 1 time unit after each
  // rising edge.
  task automatic play();
    int n, e, d;
    n = q.size();
    for (int k = 0; k < n + LAT + 2; k++) begin
      @(negedge CLK);
      if (k < n) begin
        VGA_PIXEL_X = q[k].x;
        VGA_PIXEL_Y = q[k].y;
      end else begin
        VGA_PIXEL_X = 10'd1023;
        VGA_PIXEL_Y = 10'd1023;
      end
      d = k - LAT;
      PIXEL_IN = (d >= 0 && d < n) ? q[d].pix : 8'h00;
      @(posedge CLK);
      #1;
      d = k - LAT - 1;
      e = (d >= 0 && d < n) ? q[d].exp : -1;
      chk("valid", 32'(RESULT_VALID), (e >= 0) ? 32'd1 : 32'd0);
      if (e >= 0) begin
        chk("result", 32'(RESULT), 32'(e));
        hold = 3'(e);
      end else begin
        chk("hold", 32'(RESULT), 32'(hold));
      end
    end
    q.delete();
  endtask

  initial begin
    int r, b;
    RESET_N     = 1'b0;
    PIXEL_IN    = 8'h00;
    VGA_PIXEL_X = 10'd1023;
    VGA_PIXEL_Y = 10'd1023;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_result", 32'(RESULT), 32'd0);
    chk("reset_valid", 32'(RESULT_VALID), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Full red raster -> red square.
    gap(5);
    raster(8'hE0);
    play();

    // Frame interrupted by reset around row 50; remainder must be ignored,
    // next full blue raster -> blue square.
    q.push_back(mk(0, 0, 8'h03));
    for (int i = 0; i < 300; i++) q.push_back(mk($urandom_range(W-1, 0), $urandom_range(50, 1), 8'h03));
    play();
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset_result", 32'(RESULT), 32'd0);
    chk("async_reset_valid", 32'(RESULT_VALID), 32'd0);
    hold = 3'b000;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 300; i++) q.push_back(mk($urandom_range(W-1, 0), $urandom_range(H-2, 51), 8'h03));
    q.push_back(mk(W-1, H-1, 8'h03));
    raster(8'h03);
    play();

    // Back-to-back sparse frames: each (0,0) coincides with the previous DECIDE.
    sparse_frame(0, 0, 0, 20, 60, 100, 0, 3820, 50, 50, 8'h00);      // blue triangle
    sparse_frame(30, 90, 30, 0, 0, 0, 2850, 500, 50, 50, 8'h00);     // red diamond
    sparse_frame(0, 0, 0, 0, 0, 0, 1500, 1000, 20, 20, 8'h00);       // below threshold
    sparse_frame(0, 0, 0, 0, 0, 0, 3000, 3000, 20, 20, 8'h00);       // equal counts
    sparse_frame(10, 0, 18, 0, 0, 0, 1971, 0, 10, 10, 8'hE0);        // 2000 incl. (0,0), tri edge
    sparse_frame(0, 0, 0, 0, 0, 0, 1999, 0, 10, 10, 8'h00);          // 1999 -> none
    sparse_frame(10, 0, 19, 0, 0, 0, 2071, 0, 10, 10, 8'h00);        // triangle just over
    sparse_frame(0, 260, 0, 0, 0, 0, 1800, 0, 10, 10, 8'h00);        // W1 saturates
    // Restart: a blue-heavy run is abandoned when (0,0) reappears mid-frame.
    q.push_back(mk(0, 0, 8'h03));
    for (int i = 0; i < 2100; i++) q.push_back(mk($urandom_range(W-1, 0), ry_nonband(1, H-2), 8'h03));
    sparse_frame(5, 5, 40, 0, 0, 0, 2000, 0, 10, 10, 8'h00);
    play();

    // Randomised totals with idle gaps between frames.
    for (int f = 0; f < 2; f++) begin
      gap($urandom_range(20, 1));
      r = $urandom_range(2600, 1400);
      b = $urandom_range(2600, 1400);
      sparse_frame($urandom_range(40, 0), $urandom_range(40, 0), $urandom_range(40, 0),
                   $urandom_range(40, 0), $urandom_range(40, 0), $urandom_range(40, 0),
                   r, b, 20, 20, bg_pix());
    end
    play();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
